// File: rtl/tune_pkg.sv
// Shared types and constants for the tune period decoder.
package tune_pkg;

  typedef enum logic [1:0] {
    StSilent,
    StAcquire,
    StLocked
  } tune_state_e;

  localparam int unsigned PeriodWDefault = 16;
  localparam int unsigned SyncDepth      = 2;

  // Unsigned compare-and-subtract so the difference never wraps.
  function automatic logic within_tol(input logic [31:0] a, input logic [31:0] b,
                                      input int unsigned tol);
    logic [31:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return diff <= tol;
  endfunction

endpackage

// File: rtl/tune_edge_sync.sv
// Multi-flop synchronizer followed by a one-cycle rising-edge pulse.
module tune_edge_sync
  import tune_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic [SyncDepth-1:0] sync_q;
  logic                 last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncDepth-2:0], d_i};
      last_q <= sync_q[SyncDepth-1];
    end
  end

  assign sync_o = sync_q[SyncDepth-1];
  assign rise_o = sync_q[SyncDepth-1] & ~last_q;

endmodule

// File: rtl/tune_period_decoder.sv
// Measures the speaker square-wave period, locks onto stable tones and flags silence.
// Define TUNE_PERIOD_DECODER_DIFF_CHECK_EN to monitor the complementary speaker bit.
module tune_period_decoder
  import tune_pkg::*;
#(
  parameter int unsigned PERIOD_W       = PeriodWDefault,
  parameter int unsigned STABLE_COUNT   = 3,
  parameter int unsigned TOLERANCE      = 2,
  parameter int unsigned SILENCE_CYCLES = 1000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          speaker_i,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o,
  output logic                locked_o,
  output logic                silent_o,
  output logic                diff_err_o
);

  localparam int unsigned MatchW = $clog2(STABLE_COUNT) + 1;
  localparam logic [PERIOD_W-1:0] SilMax  = PERIOD_W'(SILENCE_CYCLES);
  localparam logic [PERIOD_W-1:0] SilLast = PERIOD_W'(SILENCE_CYCLES - 1);
  localparam logic [MatchW-1:0]   LockAt  = MatchW'(STABLE_COUNT - 1);

  tune_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic [MatchW-1:0]   match_q, match_d, match_nxt;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pvalid_q, pvalid_d;
  logic [PERIOD_W-1:0] meas;
  logic                edge_evt, spk_p_sync, silence_hit;

  tune_edge_sync u_sync_p (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (speaker_i[0]),
    .sync_o (spk_p_sync),
    .rise_o (edge_evt)
  );

  assign meas        = cnt_q + 1'b1;
  assign silence_hit = (cnt_q >= SilLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q >= SilMax) ? SilMax : cnt_q + 1'b1;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    match_d    = match_q;
    match_nxt  = '0;
    period_d   = period_q;
    pvalid_d   = 1'b0;
    if (edge_evt) cnt_d = '0;

    unique case (state_q)
      StSilent: begin
        if (edge_evt) begin
          state_d    = StAcquire;
          match_d    = '0;
          prev_vld_d = 1'b0;
        end
      end
      StAcquire: begin
        if (edge_evt) begin
          if (prev_vld_q && within_tol(32'(meas), 32'(prev_q), TOLERANCE)) begin
            match_nxt = match_q + 1'b1;
          end
          match_d    = match_nxt;
          prev_d     = meas;
          prev_vld_d = 1'b1;
          if (match_nxt == LockAt) begin
            state_d  = StLocked;
            period_d = meas;
            pvalid_d = 1'b1;
          end
        end else if (silence_hit) begin
          state_d = StSilent;
        end
      end
      StLocked: begin
        if (edge_evt) begin
          if (!within_tol(32'(meas), 32'(period_q), TOLERANCE)) begin
            state_d    = StAcquire;
            prev_d     = meas;
            prev_vld_d = 1'b1;
            match_d    = '0;
          end
        end else if (silence_hit) begin
          state_d = StSilent;
        end
      end
      default: state_d = StSilent;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StSilent;
      cnt_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      match_q    <= '0;
      period_q   <= '0;
      pvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      match_q    <= match_d;
      period_q   <= period_d;
      pvalid_q   <= pvalid_d;
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = pvalid_q;
  assign locked_o       = (state_q == StLocked);
  assign silent_o       = (state_q == StSilent);

`ifdef TUNE_PERIOD_DECODER_DIFF_CHECK_EN
  logic       spk_n_sync, unused_rise_n;
  logic [1:0] eq_cnt_q, eq_cnt_d;
  logic       diff_err_q, diff_err_d, bits_eq;

  tune_edge_sync u_sync_n (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (speaker_i[1]),
    .sync_o (spk_n_sync),
    .rise_o (unused_rise_n)
  );

  assign bits_eq = (spk_p_sync == spk_n_sync);

  always_comb begin
    eq_cnt_d   = '0;
    diff_err_d = diff_err_q | (bits_eq && (eq_cnt_q >= 2'd2));
    if (bits_eq) eq_cnt_d = (eq_cnt_q == 2'd3) ? eq_cnt_q : eq_cnt_q + 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      eq_cnt_q   <= '0;
      diff_err_q <= 1'b0;
    end else begin
      eq_cnt_q   <= eq_cnt_d;
      diff_err_q <= diff_err_d;
    end
  end

  assign diff_err_o = diff_err_q;
`else
  logic unused_diff;
  assign unused_diff = speaker_i[1] ^ spk_p_sync;
  assign diff_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_tune_period_decoder.sv
// Bench for tune_period_decoder: tone table plus hand-written retune/silence/reset sequences.
module tb_tune_period_decoder;

  typedef struct {
    int cyc;
    int per;
  } sb_t;

  typedef struct {
    int pa;
    int pb;
    int n;
    bit lk;
    int per;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  speaker;
  logic [15:0] period_o;
  logic        period_valid_o, locked_o, silent_o, diff_err_o;

  int  cyc = 0;
  int  n_total = 0;
  int  n_bad = 0;
  int  last_rise = 0;
  sb_t exp_q[$];
  vec_t tbl[9];

  tune_period_decoder dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .speaker_i      (speaker),
    .period_o       (period_o),
    .period_valid_o (period_valid_o),
    .locked_o       (locked_o),
    .silent_o       (silent_o),
    .diff_err_o     (diff_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    speaker = 2'b10;
    wait_cyc(2);
    rst_i = 1'b0;
  endtask

  // Every strobe must match the head of the scoreboard in cycle and value.
  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && period_valid_o) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL strobe_unexpected: got period %0d at cyc %0d, expected none",
                   period_o, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_cyc", cyc, e.cyc);
          chk("strobe_period", int'(period_o), e.per);
          chk("strobe_locked", int'(locked_o), 1);
        end
      end
    end
  endtask

  // Periods alternate pa/pb; each starts with a rising edge. The rising edge with
  // index lock_at is expected to produce a strobe 3 cycles later.
  task automatic play_tone(input int pa, input int pb, input int n, input int lock_at,
                           input int exp_p);
    int p;
    for (int i = 0; i < n; i++) begin
      p         = (i % 2 == 1) ? pb : pa;
      speaker   = 2'b01;
      last_rise = cyc;
      if (i == lock_at) exp_q.push_back('{cyc: cyc + 3, per: exp_p});
      wait_cyc(p / 2);
      speaker = 2'b10;
      wait_cyc(p - p / 2);
    end
  endtask

  initial begin
    tbl[0] = '{pa: 200, pb: 200, n: 24, lk: 1'b1, per: 200};
    tbl[1] = '{pa: 200, pb: 202, n: 10, lk: 1'b1, per: 200};
    tbl[2] = '{pa: 202, pb: 200, n: 10, lk: 1'b1, per: 202};
    tbl[3] = '{pa: 200, pb: 204, n: 10, lk: 1'b0, per: 0};
    tbl[4] = '{pa: 200, pb: 203, n: 10, lk: 1'b0, per: 0};
    tbl[5] = '{pa: 150, pb: 150, n: 6,  lk: 1'b1, per: 150};
    tbl[6] = '{pa: 4,   pb: 4,   n: 10, lk: 1'b1, per: 4};
    tbl[7] = '{pa: 999, pb: 999, n: 5,  lk: 1'b1, per: 999};
    tbl[8] = '{pa: 1001, pb: 1001, n: 5, lk: 1'b0, per: 0};

    rst_i   = 1'b1;
    speaker = 2'b10;
    fork
      monitor();
    join_none

    // Reset then idle.
    do_reset();
    chk("rst_silent", int'(silent_o), 1);
    chk("rst_locked", int'(locked_o), 0);
    chk("rst_period", int'(period_o), 0);
    chk("rst_valid", int'(period_valid_o), 0);
    chk("rst_diff", int'(diff_err_o), 0);
    wait_cyc(2000);
    chk("idle_silent", int'(silent_o), 1);

    for (int v = 0; v < 9; v++) begin
      do_reset();
      play_tone(tbl[v].pa, tbl[v].pb, tbl[v].n, tbl[v].lk ? 3 : -1, tbl[v].per);
      chk($sformatf("tbl%0d_locked", v), int'(locked_o), int'(tbl[v].lk));
      if (tbl[v].lk) begin
        chk($sformatf("tbl%0d_period", v), int'(period_o), tbl[v].per);
        chk($sformatf("tbl%0d_silent", v), int'(silent_o), 0);
      end
    end

    // Retune 200 -> 120.
    do_reset();
    play_tone(200, 200, 5, 3, 200);
    play_tone(120, 120, 1, -1, 0);
    chk("retune_still_locked", int'(locked_o), 1);
    play_tone(120, 120, 1, -1, 0);
    chk("retune_drop", int'(locked_o), 0);
    chk("retune_hold_period", int'(period_o), 200);
    play_tone(120, 120, 3, 1, 120);
    chk("retune_locked", int'(locked_o), 1);
    chk("retune_period", int'(period_o), 120);

    // Silence while locked at 200.
    do_reset();
    play_tone(200, 200, 5, 3, 200);
    wait_cyc(last_rise + 1002 - cyc);
    chk("sil_pre_silent", int'(silent_o), 0);
    chk("sil_pre_locked", int'(locked_o), 1);
    wait_cyc(1);
    chk("sil_silent", int'(silent_o), 1);
    chk("sil_locked", int'(locked_o), 0);
    chk("sil_period", int'(period_o), 200);

    // Reset in the middle of acquisition.
    play_tone(200, 200, 2, -1, 0);
    chk("acq_not_silent", int'(silent_o), 0);
    rst_i = 1'b1;
    wait_cyc(1);
    chk("midrst_period", int'(period_o), 0);
    chk("midrst_silent", int'(silent_o), 1);
    chk("midrst_locked", int'(locked_o), 0);
    chk("midrst_valid", int'(period_valid_o), 0);
    rst_i = 1'b0;
    play_tone(200, 200, 3, -1, 0);
    chk("relock_not_yet", int'(locked_o), 0);
    play_tone(200, 200, 2, 0, 200);
    chk("relock_locked", int'(locked_o), 1);

    // Differential fault: both bits high for 5 cycles.
    do_reset();
    wait_cyc(5);
    chk("diff_clean", int'(diff_err_o), 0);
    speaker = 2'b11;
    wait_cyc(5);
    speaker = 2'b10;
    wait_cyc(10);
`ifdef TUNE_PERIOD_DECODER_DIFF_CHECK_EN
    chk("diff_set", int'(diff_err_o), 1);
    wait_cyc(50);
    chk("diff_sticky", int'(diff_err_o), 1);
    do_reset();
    chk("diff_cleared", int'(diff_err_o), 0);
`else
    chk("diff_tied_off", int'(diff_err_o), 0);
`endif

    wait_cyc(5);
    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
